// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state codes, frame constants and bit-timing helper.
// Used by uart_tx and the matching receiver.
package uart_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;

    localparam int DATA_BITS  = 8;
    localparam int STOP_BITS  = 1;
    localparam int BREAK_BITS = 11;

    // Integer division; any remainder is absorbed as a small bit-rate error.
    function automatic int cycles_per_bit(input int clk_hz, input int bit_rate);
        return clk_hz / bit_rate;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Per-bit cycle counter: counts 0..CYCLES_PER_BIT-1 and wraps, with a synchronous
// clear and a single-cycle tick on the last count of each bit.
module uart_bit_timer #(
    parameter int CYCLES_PER_BIT = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    output logic bit_tick_o
);

    localparam logic [15:0] LAST_COUNT = 16'(CYCLES_PER_BIT - 1);

    logic [15:0] count_q, count_d;

    always_comb begin
        count_d = count_q + 16'd1;
        if (clear_i || (count_q == LAST_COUNT)) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign bit_tick_o = (count_q == LAST_COUNT);

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first, registered idle-high line.
// Optional line-break generation is enabled with `define UART_TX_BREAK_EN.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | line high, waiting for send_en (or send_break)
// START    | start bit, line low
// DATA     | data bits 0..7 from shift register LSB
// STOP     | stop bit, line high
// BREAK    | 11 bit-times low followed by 1 bit-time high (mark)
module uart_tx
    import uart_pkg::*;
#(
    parameter int BIT_RATE = 9600,
    parameter int CLK_HZ   = 100000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       send_en,
    input  logic [7:0] send_data,
`ifdef UART_TX_BREAK_EN
    input  logic       send_break,
`endif
    output logic       busy,
    output logic       uart_txd
);

    localparam int CYCLES_PER_BIT = cycles_per_bit(CLK_HZ, BIT_RATE);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    generate
        if (CYCLES_PER_BIT < 2 || CYCLES_PER_BIT >= 65536) begin : g_bad_cpb
            $error("uart_tx: CLK_HZ/BIT_RATE must be in [2, 65535]");
        end
        if (STOP_BITS != 1 || BREAK_BITS + 1 > 16) begin : g_bad_frame
            $error("uart_tx: unsupported frame constants");
        end
    endgenerate

    logic [2:0] state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       txd_q, txd_d;
    logic       busy_q;
    logic       bit_tick;
`ifdef UART_TX_BREAK_EN
    logic [3:0] brk_cnt_q, brk_cnt_d;
`endif

    uart_bit_timer #(
        .CYCLES_PER_BIT(CYCLES_PER_BIT)
    ) u_bit_timer (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (state_q == ST_IDLE),
        .bit_tick_o(bit_tick)
    );

    // txd_d is the line level for the next cycle, so the pin is a plain flop.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        txd_d     = txd_q;
`ifdef UART_TX_BREAK_EN
        brk_cnt_d = brk_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                txd_d = 1'b1;
`ifdef UART_TX_BREAK_EN
                if (send_break) begin
                    state_d   = ST_BREAK;
                    brk_cnt_d = '0;
                    txd_d     = 1'b0;
                end else
`endif
                if (send_en) begin
                    state_d = ST_START;
                    shift_d = send_data;
                    txd_d   = 1'b0;
                end
            end
            ST_START: begin
                if (bit_tick) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                    txd_d     = shift_q[0];
                end
            end
            ST_DATA: begin
                if (bit_tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = ST_STOP;
                        txd_d   = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        txd_d     = shift_q[1];
                    end
                end
            end
            ST_STOP: begin
                if (bit_tick) begin
                    state_d = ST_IDLE;
                    txd_d   = 1'b1;
                end
            end
`ifdef UART_TX_BREAK_EN
            ST_BREAK: begin
                if (bit_tick) begin
                    if (brk_cnt_q == 4'(BREAK_BITS)) begin
                        state_d = ST_IDLE;
                        txd_d   = 1'b1;
                    end else begin
                        brk_cnt_d = brk_cnt_q + 4'd1;
                        if (brk_cnt_q == 4'(BREAK_BITS - 1)) begin
                            txd_d = 1'b1;
                        end
                    end
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
                txd_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            txd_q     <= 1'b1;
            busy_q    <= 1'b0;
`ifdef UART_TX_BREAK_EN
            brk_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            txd_q     <= txd_d;
            busy_q    <= (state_d != ST_IDLE);
`ifdef UART_TX_BREAK_EN
            brk_cnt_q <= brk_cnt_d;
`endif
        end
    end

    assign uart_txd = txd_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed scenarios plus randomized frames,
// compared cycle by cycle against an expected-waveform queue.
module tb_uart_tx;

    localparam int TB_CLK_HZ   = 1000;
    localparam int TB_BIT_RATE = 100;
    localparam int CPB         = TB_CLK_HZ / TB_BIT_RATE;
    localparam int FRAME       = 10 * CPB;

    logic       clk = 1'b0;
    logic       reset;
    logic       send_en;
    logic [7:0] send_data;
    logic       busy;
    logic       uart_txd;
`ifdef UART_TX_BREAK_EN
    logic       send_break;
`endif

    uart_tx #(
        .BIT_RATE(TB_BIT_RATE),
        .CLK_HZ  (TB_CLK_HZ)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .send_en   (send_en),
        .send_data (send_data),
`ifdef UART_TX_BREAK_EN
        .send_break(send_break),
`endif
        .busy      (busy),
        .uart_txd  (uart_txd)
    );

    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_pass   = 0;
    int    cyc      = 0;
    string test_name = "";
    logic  exp_txd[$];
    logic  exp_busy[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Expected line level in cycle i of an 8N1 frame carrying byte b.
    function automatic logic frame_bit(input logic [7:0] b, input int i);
        int k;
        k = i / CPB;
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        return 1'b1;
    endfunction

    task automatic push_frame(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            exp_txd.push_back(frame_bit(b, i));
            exp_busy.push_back(1'b1);
        end
    endtask

    task automatic push_level(input logic lvl, input logic bsy, input int n);
        for (int i = 0; i < n; i++) begin
            exp_txd.push_back(lvl);
            exp_busy.push_back(bsy);
        end
    endtask

    task automatic step();
        logic et, eb;
        @(negedge clk);
        et = exp_txd.pop_front();
        eb = exp_busy.pop_front();
        check($sformatf("%s txd@%0d", test_name, cyc), {31'd0, uart_txd}, {31'd0, et});
        check($sformatf("%s busy@%0d", test_name, cyc), {31'd0, busy}, {31'd0, eb});
        cyc++;
    endtask

    task automatic run_queue();
        while (exp_txd.size() > 0) step();
    endtask

    task automatic begin_test(input string name);
        test_name = name;
        cyc = 0;
    endtask

    initial begin
        logic [7:0] b;
        int gap, p;

        reset     = 1'b1;
        send_en   = 1'b1;
        send_data = 8'hA5;
`ifdef UART_TX_BREAK_EN
        send_break = 1'b0;
`endif

        // reset held 3 cycles with send_en high: must stay idle, not accept
        begin_test("reset_hold");
        push_level(1'b1, 1'b0, 3);
        run_queue();
        reset   = 1'b0;
        send_en = 1'b0;
        push_level(1'b1, 1'b0, 3);
        run_queue();

        // single frame 0x55
        begin_test("frame55");
        send_en = 1'b1; send_data = 8'h55;
        push_frame(8'h55, FRAME);
        push_level(1'b1, 1'b0, 3);
        step();
        send_en = 1'b0;
        run_queue();

        // back-to-back 0x00 then 0xFF with send_en held high
        begin_test("b2b");
        send_en = 1'b1; send_data = 8'h00;
        push_frame(8'h00, FRAME);
        push_level(1'b1, 1'b0, 1);
        push_frame(8'hFF, FRAME);
        push_level(1'b1, 1'b0, 3);
        for (int i = 0; exp_txd.size() > 0; i++) begin
            step();
            if (i == 0) send_data = 8'hFF;
            if (i == FRAME + 1) send_en = 1'b0;
        end

        // data changes and extra requests during the frame are ignored
        begin_test("ignore");
        send_en = 1'b1; send_data = 8'hA3;
        push_frame(8'hA3, FRAME);
        push_level(1'b1, 1'b0, 5);
        p = $urandom_range(20, 90);
        for (int i = 0; exp_txd.size() > 0; i++) begin
            step();
            if (i == 0) begin send_en = 1'b0; send_data = 8'h00; end
            if (i == p || i == p + 3) begin
                send_en = 1'b1;
`ifdef UART_TX_BREAK_EN
                send_break = 1'b1;
`endif
            end
            if (i == p + 1 || i == p + 4) begin
                send_en = 1'b0;
`ifdef UART_TX_BREAK_EN
                send_break = 1'b0;
`endif
            end
        end

        // reset in the middle of data bit 4 of 0x0F abandons the frame
        begin_test("mid_reset");
        send_en = 1'b1; send_data = 8'h0F;
        push_frame(8'h0F, 5 * CPB + 5);
        push_level(1'b1, 1'b0, 3);
        for (int i = 0; exp_txd.size() > 0; i++) begin
            step();
            if (i == 0) send_en = 1'b0;
            if (i == 5 * CPB + 4) reset = 1'b1;
            if (i == 5 * CPB + 5) reset = 1'b0;
        end
        begin_test("after_reset");
        send_en = 1'b1; send_data = 8'h81;
        push_frame(8'h81, FRAME);
        push_level(1'b1, 1'b0, 2);
        step();
        send_en = 1'b0;
        run_queue();

        // randomized frames with noisy inputs during transmission
        for (int t = 0; t < 20; t++) begin
            begin_test($sformatf("rand%0d", t));
            b   = 8'($urandom);
            gap = $urandom_range(1, 4);
            send_en = 1'b1; send_data = b;
            push_frame(b, FRAME);
            push_level(1'b1, 1'b0, gap);
            p = $urandom_range(1, FRAME - 6);
            for (int i = 0; exp_txd.size() > 0; i++) begin
                step();
                if (i == 0) send_en = 1'b0;
                if (i < FRAME) send_data = 8'($urandom);
                if (i == p) send_en = 1'b1;
                if (i == p + 1) send_en = 1'b0;
            end
        end

`ifdef UART_TX_BREAK_EN
        // break takes priority over a simultaneous send_en
        begin_test("break");
        send_break = 1'b1; send_en = 1'b1; send_data = 8'h5A;
        push_level(1'b0, 1'b1, 11 * CPB);
        push_level(1'b1, 1'b1, CPB);
        push_level(1'b1, 1'b0, 4);
        step();
        send_break = 1'b0; send_en = 1'b0;
        run_queue();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
